adc_capture_ctrl: RTL and testbench

Capture sequencer between the SYZYGY ADC front end and the sample FIFO, running entirely in the ADC data clock domain. It replaces free-running FIFO write enabling with an armed, counted acquisition. On a start pulse it waits for the interface to become ready, then writes exactly N paired samples into the FIFO. It reports busy/done/overrun status for host-side wires.

---
 rtl/adc_capture_pkg.sv | 14 +
 rtl/adc_capture_ctrl.sv | 159 +++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DATA_W_DEFAULT = 16;
    localparam int DECIM_W        = 8;

endpackage

// File: rtl/adc_capture_ctrl.sv
// Armed, counted capture sequencer between the SYZYGY ADC front end and the
// sample FIFO. Single clock domain (adc_data_clk).
// Optional feature macro: ADC_CAPTURE_DECIM_EN adds the decim port and an
// 8-bit decimation counter; without it every qualified sample is eligible.
//
// FIFO handshake: fifo_wr_en is a one-cycle valid strobe with no ready
// return; fifo_prog_full acts as a "not ready" level that is sampled in the
// qualifying cycle. A write registered on that edge is never withdrawn, so a
// sample seen while prog_full is high is dropped (and flagged) instead of
// being stalled.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int CNT_W  = 24,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    sample_count,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [DECIM_W-1:0]  decim,
`endif
    input  logic                mmcm_locked,
    input  logic                idelay_rdy,
    input  logic                data_valid,
    input  logic [DATA_W-1:0]   adc_data_1,
    input  logic [DATA_W-1:0]   adc_data_2,
    input  logic                fifo_prog_full,
    output logic                fifo_wr_en,
    output logic [2*DATA_W-1:0] fifo_din,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [CNT_W-1:0]    written,
    output state_t              dbg_state
);

    state_t            state;
    state_t            state_n;
    logic              link_ok;
    logic              accept;
    logic              do_write;
    logic              do_drop;
    logic              decim_tick;
    logic [CNT_W-1:0]  cnt_lat;
    logic [CNT_W-1:0]  written_inc;

    assign link_ok     = mmcm_locked & idelay_rdy & data_valid;
    assign written_inc = written + 1'b1;
    assign busy        = (state == ARM) || (state == CAPTURE);
    assign done        = (state == DONE);
    assign dbg_state   = state;

`ifdef ADC_CAPTURE_DECIM_EN
    logic [DECIM_W-1:0] decim_lat;
    logic [DECIM_W-1:0] decim_cnt;
    logic               qualified;

    // A qualified sample is any CAPTURE cycle with the link up; abort suppresses it.
    assign qualified  = (state == CAPTURE) && link_ok && !abort;
    assign decim_tick = (decim_cnt == '0);

    // Decimation counter: advances on every qualified sample, written or dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            decim_lat <= '0;
            decim_cnt <= '0;
        end else if (accept) begin
            decim_lat <= decim;
            decim_cnt <= '0;
        end else if (qualified) begin
            decim_cnt <= (decim_cnt == decim_lat) ? '0 : decim_cnt + 1'b1;
        end
    end
`else
    assign decim_tick = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus write/drop/accept decisions for the current cycle.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        do_write = 1'b0;
        do_drop  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = ARM;
                end
            end
            ARM: begin
                if (link_ok && !fifo_prog_full) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (link_ok && decim_tick) begin
                    if (fifo_prog_full) begin
                        do_drop = 1'b1;
                    end else begin
                        do_write = 1'b1;
                        // A zero count means continuous capture: never completes.
                        if ((cnt_lat != '0) && (written_inc == cnt_lat)) begin
                            state_n = DONE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort beats everything, including a simultaneous start.
        if (abort) begin
            state_n  = IDLE;
            accept   = 1'b0;
            do_write = 1'b0;
            do_drop  = 1'b0;
        end
    end

    // Registered FIFO write, written counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lat    <= '0;
            written    <= '0;
            overrun    <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else begin
            fifo_wr_en <= do_write;
            if (accept) begin
                cnt_lat <= sample_count;
                written <= '0;
                overrun <= 1'b0;
            end
            if (do_write) begin
                fifo_din <= {adc_data_1, adc_data_2};
                if (written != '1) begin
                    written <= written_inc;
                end
            end
            if (do_drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed scenarios plus random
// captures, with expected FIFO writes predicted from the recorded stimulus.
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

    localparam int CNT_W  = 24;
    localparam int DATA_W = 16;
    localparam int RECN   = 4096;
    localparam int EW     = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                start;
    logic                abort;
    logic [CNT_W-1:0]    sample_count;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0]          decim;
`endif
    logic                mmcm_locked;
    logic                idelay_rdy;
    logic                data_valid;
    logic [DATA_W-1:0]   adc_data_1;
    logic [DATA_W-1:0]   adc_data_2;
    logic                fifo_prog_full;
    logic                fifo_wr_en;
    logic [2*DATA_W-1:0] fifo_din;
    logic                busy;
    logic                done;
    logic                overrun;
    logic [CNT_W-1:0]    written;
    state_t              dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit          rec_link[RECN];
    bit          rec_pf[RECN];
    bit          rec_ab[RECN];
    logic [31:0] rec_dat[RECN];

    // Entry: {cycle stamp[15:0], done, busy, fifo_din[31:0]}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] act_q[$];

    adc_capture_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .sample_count   (sample_count),
`ifdef ADC_CAPTURE_DECIM_EN
        .decim          (decim),
`endif
        .mmcm_locked    (mmcm_locked),
        .idelay_rdy     (idelay_rdy),
        .data_valid     (data_valid),
        .adc_data_1     (adc_data_1),
        .adc_data_2     (adc_data_2),
        .fifo_prog_full (fifo_prog_full),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_din       (fifo_din),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun),
        .written        (written),
        .dbg_state      (dbg_state)
    );

    // Cycle counter: cycle c is the interval that ends at the (c+1)th posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every FIFO write with its cycle stamp and status flags.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) act_q.push_back({cyc[15:0], done, busy, fifo_din});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (lk=0 picks a random broken link), record it.
    task automatic step(input bit lk, input bit pf, input bit st, input bit ab,
                        input bit rs, input logic [31:0] dat);
        logic [2:0] lv;
        if (cyc >= RECN) begin
            $display("FAIL rec_overflow cycle=%0d limit=%0d", cyc, RECN);
            $fatal(1, "record overflow");
        end
        lv = lk ? 3'b111 : 3'($urandom_range(0, 6));
        {mmcm_locked, idelay_rdy, data_valid} = lv;
        fifo_prog_full = pf;
        start          = st;
        abort          = ab;
        reset          = rs;
        adc_data_1     = dat[31:16];
        adc_data_2     = dat[15:0];
        rec_link[cyc]  = lk;
        rec_pf[cyc]    = pf;
        rec_ab[cyc]    = ab | rs;
        rec_dat[cyc]   = dat;
        @(negedge clk);
    endtask

    // Reference: start accepted in cycle s; replay cycles s+1..e by the rules:
    // arm until link up and not full (that cycle writes nothing), then every
    // (d+1)th link-up sample is written one cycle later, or dropped if full.
    task automatic model_capture(input int s, input int e, input int n, input int d,
                                 output int w, output bit ov, output bit dn);
        int  k;
        bit  capt;
        bit  fin;
        w = 0; ov = 1'b0; dn = 1'b0; k = 0; capt = 1'b0;
        for (int c = s + 1; c <= e; c++) begin
            if (rec_ab[c]) return;
            if (!capt) begin
                if (rec_link[c] && !rec_pf[c]) capt = 1'b1;
            end else if (rec_link[c]) begin
                if (k % (d + 1) == 0) begin
                    if (rec_pf[c]) begin
                        ov = 1'b1;
                    end else begin
                        w++;
                        fin = (n != 0) && (w == n);
                        exp_q.push_back({16'(c + 1), fin, !fin, rec_dat[c]});
                        if (fin) begin
                            dn = 1'b1;
                            return;
                        end
                    end
                end
                k++;
            end
        end
    endtask

    task automatic check_stream(input string tag);
        #1;
        chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            chk({tag, "_wr"}, 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
        act_q.delete();
    endtask

    function automatic logic [31:0] ramp(input int i);
        return {16'(i), 16'(i)};
    endfunction

    initial begin
        int s, n, d, len, mw;
        bit mov, mdn;
        sample_count = '0;
`ifdef ADC_CAPTURE_DECIM_EN
        decim = 8'd0;
`endif
        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("rst_wr_en",   64'(fifo_wr_en), 64'(0));
        chk("rst_din",     64'(fifo_din),   64'(0));
        chk("rst_busy",    64'(busy),       64'(0));
        chk("rst_done",    64'(done),       64'(0));
        chk("rst_overrun", 64'(overrun),    64'(0));
        chk("rst_written", 64'(written),    64'(0));
        chk("rst_state",   64'(dbg_state),  64'(IDLE));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Count capture: N=4, ramp 1..8 starting on the first CAPTURE cycle
        sample_count = 24'd4;
        s = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ramp(i));
        #1;
        chk("cnt_pulses",  64'(act_q.size()), 64'(4));
        chk("cnt_first",   64'(act_q[0][31:0]), 64'(ramp(1)));
        chk("cnt_written", 64'(written), 64'(4));
        chk("cnt_done",    64'(done),    64'(1));
        chk("cnt_busy",    64'(busy),    64'(0));
        model_capture(s, cyc - 1, 4, 0, mw, mov, mdn);
        check_stream("cnt");

        // Arm wait: link down for 10 cycles after start
        sample_count = 24'd3;
        s = cyc;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, $urandom);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        #1;
        chk("arm_busy",    64'(busy),          64'(1));
        chk("arm_state",   64'(dbg_state),     64'(ARM));
        chk("arm_nowrite", 64'(act_q.size()),  64'(0));
        chk("arm_written", 64'(written),       64'(0));
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        chk("arm_done",    64'(done),          64'(1));
        model_capture(s, cyc - 1, 3, 0, mw, mov, mdn);
        check_stream("arm");

        // Backpressure: prog_full for 3 qualified cycles
        sample_count = 24'd8;
        s = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 17; i++)
            step(1'b1, (i >= 3 && i <= 5), 1'b0, 1'b0, 1'b0, ramp(i));
        #1;
        chk("bp_overrun", 64'(overrun), 64'(1));
        chk("bp_written", 64'(written), 64'(8));
        chk("bp_done",    64'(done),    64'(1));
        model_capture(s, cyc - 1, 8, 0, mw, mov, mdn);
        chk("bp_model_ov", 64'(overrun), 64'(mov));
        check_stream("bp");

        // Abort in continuous mode after 5 writes
        sample_count = 24'd0;
        s = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ramp(i + 16));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ramp(99));
        #1;
        chk("ab_state",   64'(dbg_state), 64'(IDLE));
        chk("ab_done",    64'(done),      64'(0));
        chk("ab_busy",    64'(busy),      64'(0));
        chk("ab_written", 64'(written),   64'(5));
        model_capture(s, cyc - 1, 0, 0, mw, mov, mdn);
        check_stream("ab");
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        #1;
        chk("ab_nowrite", 64'(act_q.size()), 64'(0));
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, $urandom);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        #1;
        chk("stab_state",   64'(dbg_state),     64'(IDLE));
        chk("stab_written", 64'(written),       64'(5));
        chk("stab_nowrite", 64'(act_q.size()),  64'(0));

`ifdef ADC_CAPTURE_DECIM_EN
        // Decimation: D=2, N=3, ramp 0..11 -> samples 0, 3, 6
        decim = 8'd2;
        sample_count = 24'd3;
        s = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ramp(i));
        #1;
        chk("dec_n",  64'(act_q.size()), 64'(3));
        chk("dec_s1", 64'(act_q[1][31:0]), 64'(ramp(3)));
        chk("dec_s2", 64'(act_q[2][31:0]), 64'(ramp(6)));
        chk("dec_done", 64'(done), 64'(1));
        model_capture(s, cyc - 1, 3, 2, mw, mov, mdn);
        check_stream("dec");
`endif

        // Random captures against the reference
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 10);
`ifdef ADC_CAPTURE_DECIM_EN
            d = $urandom_range(0, 3);
            decim = 8'(d);
`else
            d = 0;
`endif
            sample_count = CNT_W'(n);
            s = cyc;
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, $urandom);
            len = n * (d + 1) * 2 + 12;
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
                     1'b0, 1'b0, 1'b0, $urandom);
            model_capture(s, cyc - 1, n, d, mw, mov, mdn);
            check_stream("rnd");
            chk("rnd_written", 64'(written), 64'(mw));
            chk("rnd_overrun", 64'(overrun), 64'(mov));
            chk("rnd_done",    64'(done),    64'(mdn));
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, $urandom);
            #1;
            chk("rnd_idle", 64'(dbg_state), 64'(IDLE));
        end

        // Reset mid-capture with a write pending
        sample_count = 24'd0;
`ifdef ADC_CAPTURE_DECIM_EN
        decim = 8'd0;
`endif
        s = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ramp(i + 40));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ramp(77));
        chk("mrst_wr_en",   64'(fifo_wr_en), 64'(0));
        chk("mrst_din",     64'(fifo_din),   64'(0));
        chk("mrst_busy",    64'(busy),       64'(0));
        chk("mrst_written", 64'(written),    64'(0));
        chk("mrst_overrun", 64'(overrun),    64'(0));
        chk("mrst_state",   64'(dbg_state),  64'(IDLE));
        model_capture(s, cyc - 1, 0, 0, mw, mov, mdn);
        check_stream("mrst");
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        #1;
        chk("mrst_nowrite", 64'(act_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
